axi_wdata_issue: RTL and testbench

Downstream drain stage for `axi_wdata_sfifo`. It pops width-converted write beats (data, strobe, last) from the FIFO read port and presents them as an AXI4 W channel toward the slave/DDR side. It only releases a burst's beats after the matching AW has been accepted downstream, tracked through an AW credit counter. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, so the W channel sustains one beat per clock.

---
 rtl/axi_wdata_pkg.sv | 17 +
 rtl/axi_w_skid_buf.sv | 47 ++++
 rtl/axi_wdata_issue.sv | 77 +++++++
 tb/tb_axi_wdata_issue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wdata_pkg.sv
// Shared types and constants for the AXI W-channel drain stage.
package axi_wdata_pkg;

   localparam int BEAT_DATA_WTH = 64;
   localparam int BEAT_STRB_WTH = BEAT_DATA_WTH / 8;

   // The output buffer only has to cover the FIFO's one-cycle read latency plus the beat on the bus.
   localparam int OBUF_DEPTH = 2;
   localparam int OCC_W      = $clog2(OBUF_DEPTH + 1);

   typedef struct packed {
      logic [BEAT_DATA_WTH-1:0] data;
      logic [BEAT_STRB_WTH-1:0] strb;
      logic                     last;
   } beat_t;

endpackage

// File: rtl/axi_w_skid_buf.sv
// Two-entry in-order beat buffer. The head entry drives the W channel and holds
// until it is handshaken, so the outputs stay stable under backpressure.
module axi_w_skid_buf
   import axi_wdata_pkg::*;
#(
   parameter  int DATA_WTH = BEAT_DATA_WTH,
   localparam int BEAT_W   = DATA_WTH + DATA_WTH / 8 + 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en,
   input  logic [BEAT_W-1:0] wr_beat,
   input  logic              ready,
   output logic              valid,
   output logic [BEAT_W-1:0] head,
   output logic [OCC_W-1:0]  occ
);

   localparam int PTR_W = $clog2(OBUF_DEPTH);

   logic [BEAT_W-1:0] mem [OBUF_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              pop;

   assign valid = (occ != '0);
   assign pop   = valid & ready;
   assign head  = mem[rd_ptr];

   // Storage, pointers and occupancy; entries are cleared so the W outputs read zero out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_beat;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         occ <= occ + OCC_W'(wr_en) - OCC_W'(pop);
      end
   end

endmodule

// File: rtl/axi_wdata_issue.sv
// Drains width-converted write beats from the FIFO onto the AXI W channel,
// releasing each burst only after its AW has been accepted downstream.
module axi_wdata_issue
   import axi_wdata_pkg::*;
#(
   parameter int DATA_WTH     = 64,
   parameter int CREDIT_DEPTH = 4,
   parameter int CREDIT_W     = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  aw_accept,
   output logic                  credit_full,
   output logic                  fifo_ren,
   input  logic [DATA_WTH-1:0]   fifo_rdata,
   input  logic [DATA_WTH/8-1:0] fifo_rstrb,
   input  logic                  fifo_rlast,
   input  logic                  fifo_empty,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   output logic [DATA_WTH-1:0]   m_wdata,
   output logic [DATA_WTH/8-1:0] m_wstrb,
   output logic                  m_wlast,
   output logic                  credit_ovf
);

   localparam int BEAT_W = DATA_WTH + DATA_WTH / 8 + 1;

   logic [CREDIT_W-1:0] credit;
   logic [CREDIT_W-1:0] cr_eff;
   logic                rd_pend;
   logic                ret;
   logic                acc;
   logic                hs;
   logic [OCC_W-1:0]    occ;
   logic [2:0]          free;
   logic [BEAT_W-1:0]   head;

   assign ret         = rd_pend & fifo_rlast;
   assign credit_full = (credit == CREDIT_W'(CREDIT_DEPTH));
   assign acc         = aw_accept & ~credit_full;
   // Subtracting the returning last beat keeps the next burst's first pop from sneaking in on the same cycle.
   assign cr_eff      = credit - CREDIT_W'(ret);
   assign hs          = m_wvalid & m_wready;
   // Slots still unclaimed once the in-flight pop lands, counting the beat leaving this cycle.
   assign free        = 3'(OBUF_DEPTH) - 3'(occ) - 3'(rd_pend) + 3'(hs);
   assign fifo_ren    = ~fifo_empty & (cr_eff != '0) & (free != '0);

   // AW credit accounting, read-latency tracking and sticky overflow flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         credit     <= '0;
         rd_pend    <= 1'b0;
         credit_ovf <= 1'b0;
      end else begin
         credit  <= credit + CREDIT_W'(acc) - CREDIT_W'(ret);
         rd_pend <= fifo_ren;
         if (aw_accept & credit_full) credit_ovf <= 1'b1;
      end
   end

   axi_w_skid_buf #(
      .DATA_WTH (DATA_WTH)
   ) u_skid_buf (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (rd_pend),
      .wr_beat ({fifo_rdata, fifo_rstrb, fifo_rlast}),
      .ready   (m_wready),
      .valid   (m_wvalid),
      .head    (head),
      .occ     (occ)
   );

   assign {m_wdata, m_wstrb, m_wlast} = head;

endmodule

// File: tb/tb_axi_wdata_issue.sv
// Bench for axi_wdata_issue: FIFO read-port model plus an in-order beat scoreboard.
module tb_axi_wdata_issue;
   import axi_wdata_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        aw_accept;
   logic        credit_full;
   logic        fifo_ren;
   logic [63:0] fifo_rdata;
   logic [7:0]  fifo_rstrb;
   logic        fifo_rlast;
   logic        fifo_empty;
   logic        m_wvalid;
   logic        m_wready;
   logic [63:0] m_wdata;
   logic [7:0]  m_wstrb;
   logic        m_wlast;
   logic        credit_ovf;

   axi_wdata_issue #(
      .DATA_WTH     (64),
      .CREDIT_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .aw_accept   (aw_accept),
      .credit_full (credit_full),
      .fifo_ren    (fifo_ren),
      .fifo_rdata  (fifo_rdata),
      .fifo_rstrb  (fifo_rstrb),
      .fifo_rlast  (fifo_rlast),
      .fifo_empty  (fifo_empty),
      .m_wvalid    (m_wvalid),
      .m_wready    (m_wready),
      .m_wdata     (m_wdata),
      .m_wstrb     (m_wstrb),
      .m_wlast     (m_wlast),
      .credit_ovf  (credit_ovf)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   beat_t       fq[$];
   beat_t       exp_q[$];
   int          len_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cnt;
   logic        last_ren;
   int          beats;
   int          bursts_done;
   int          cur_len;
   int          first_v;
   int          last_c;
   logic        ren_seen;
   logic        valid_seen;
   int          hold_viol = 0;
   int          ren_empty_err = 0;
   logic        prev_stall;
   logic [63:0] prev_d;
   logic [7:0]  prev_s;
   logic        prev_l;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic load_burst(input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = {$urandom, $urandom};
         b.strb = 8'($urandom);
         b.last = (i == len - 1);
         fq.push_back(b);
         exp_q.push_back(b);
      end
      len_q.push_back(len);
      fifo_empty = 1'b0;
   endtask

   // One clock: drive inputs, observe at negedge, then model the FIFO read port after the edge.
   task automatic cyc(input logic aw, input logic rdy);
      beat_t e;
      beat_t b;
      aw_accept = aw;
      m_wready  = rdy;
      @(negedge clk);
      last_ren = fifo_ren;
      if (fifo_ren) ren_seen = 1'b1;
      if (m_wvalid) valid_seen = 1'b1;
      if (fifo_ren && fifo_empty) ren_empty_err++;
      if (prev_stall && (!m_wvalid || m_wdata !== prev_d || m_wstrb !== prev_s || m_wlast !== prev_l))
         hold_viol++;
      prev_stall = m_wvalid && !m_wready;
      prev_d     = m_wdata;
      prev_s     = m_wstrb;
      prev_l     = m_wlast;
      if (m_wvalid && first_v < 0) first_v = cnt;
      if (m_wvalid && m_wready) begin
         beats++;
         cur_len++;
         chk("sb_expected_beat", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wdata", m_wdata, e.data);
            chk("wstrb", 64'(m_wstrb), 64'(e.strb));
            chk("wlast", 64'(m_wlast), 64'(e.last));
         end
         if (m_wlast) begin
            last_c = cnt;
            bursts_done++;
            if (len_q.size() != 0) chk("burst_len", cur_len, len_q.pop_front());
            cur_len = 0;
         end
      end
      @(posedge clk);
      #1;
      if (last_ren && fq.size() != 0) begin
         b          = fq.pop_front();
         fifo_rdata = b.data;
         fifo_rstrb = b.strb;
         fifo_rlast = b.last;
      end
      fifo_empty = (fq.size() == 0);
      cnt++;
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      aw_accept = 1'b0;
      m_wready  = 1'b0;
      fq.delete();
      exp_q.delete();
      len_q.delete();
      fifo_rdata = '0;
      fifo_rstrb = '0;
      fifo_rlast = 1'b0;
      fifo_empty = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rstn       = 1'b1;
      cnt        = 0;
      cur_len    = 0;
      prev_stall = 1'b0;
      last_ren   = 1'b0;
   endtask

   // Directed scenarios followed by a randomized drain against the scoreboard.
   initial begin
      int   nb;
      int   total;
      int   len;
      int   aws;
      logic aw;

      beats       = 0;
      bursts_done = 0;
      first_v     = -1;
      last_c      = -1;
      do_reset();

      chk("rst_wvalid", 64'(m_wvalid), 64'd0);
      chk("rst_fifo_ren", 64'(fifo_ren), 64'd0);
      chk("rst_credit_full", 64'(credit_full), 64'd0);
      chk("rst_credit_ovf", 64'(credit_ovf), 64'd0);
      chk("rst_wdata", m_wdata, 64'd0);

      // Single 4-beat burst, AW at cycle 10.
      load_burst(4);
      first_v = -1;
      last_c  = -1;
      beats   = 0;
      repeat (20) cyc(cnt == 10, 1'b1);
      chk("t1_first_valid_cyc", first_v, 13);
      chk("t1_last_cyc", last_c, 16);
      chk("t1_beats", beats, 4);
      load_burst(1);
      ren_seen = 1'b0;
      repeat (6) cyc(1'b0, 1'b1);
      chk("t1_credit0_no_pop", 64'(ren_seen), 64'd0);
      cyc(1'b1, 1'b1);
      repeat (6) cyc(1'b0, 1'b1);
      chk("t1_extra_drained", exp_q.size(), 0);

      // Data waiting ahead of AW.
      load_burst(3);
      load_burst(2);
      ren_seen   = 1'b0;
      valid_seen = 1'b0;
      repeat (20) cyc(1'b0, 1'b1);
      chk("t2_no_pop_wo_aw", 64'(ren_seen), 64'd0);
      chk("t2_no_valid_wo_aw", 64'(valid_seen), 64'd0);
      beats = 0;
      cyc(1'b1, 1'b1);
      repeat (12) cyc(1'b0, 1'b1);
      chk("t2_first_burst_only", beats, 3);
      chk("t2_fifo_left", fq.size(), 2);
      cyc(1'b1, 1'b1);
      repeat (12) cyc(1'b0, 1'b1);
      chk("t2_second_burst", beats, 5);

      // Backpressure mid-burst.
      load_burst(8);
      beats = 0;
      cyc(1'b1, 1'b1);
      repeat (4) cyc(1'b0, 1'b1);
      repeat (10) cyc(1'b0, 1'b0);
      chk("t3_ren_stalled", 64'(fifo_ren), 64'd0);
      chk("t3_valid_stalled", 64'(m_wvalid), 64'd1);
      chk("t3_fifo_left", fq.size(), 4);
      chk("t3_beats_before", beats, 2);
      repeat (6) cyc(1'b0, 1'b1);
      chk("t3_contiguous_drain", beats, 8);

      // Credit limit and overflow.
      repeat (3) cyc(1'b1, 1'b1);
      chk("t4_full_after3", 64'(credit_full), 64'd0);
      cyc(1'b1, 1'b1);
      chk("t4_full_after4", 64'(credit_full), 64'd1);
      chk("t4_no_ovf_yet", 64'(credit_ovf), 64'd0);
      cyc(1'b1, 1'b1);
      chk("t4_ovf_on5", 64'(credit_ovf), 64'd1);
      chk("t4_full_on5", 64'(credit_full), 64'd1);
      beats = 0;
      repeat (4) load_burst(1);
      repeat (12) cyc(1'b0, 1'b1);
      chk("t4_four_bursts", beats, 4);
      chk("t4_full_released", 64'(credit_full), 64'd0);
      load_burst(1);
      repeat (8) cyc(1'b0, 1'b1);
      chk("t4_credit_exhausted", exp_q.size(), 1);
      cyc(1'b1, 1'b1);
      repeat (6) cyc(1'b0, 1'b1);
      chk("t4_last_drained", exp_q.size(), 0);

      // AW coinciding with a returning last beat.
      load_burst(2);
      load_burst(2);
      beats = 0;
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      chk("t5_no_pop_on_ret", 64'(last_ren), 64'd0);
      cyc(1'b0, 1'b1);
      chk("t5_pop_next_cycle", 64'(last_ren), 64'd1);
      repeat (8) cyc(1'b0, 1'b1);
      chk("t5_both_bursts", beats, 4);

      // Asynchronous reset mid-burst.
      load_burst(6);
      cyc(1'b1, 1'b1);
      repeat (4) cyc(1'b0, 1'b1);
      chk("t6_valid_before_rst", 64'(m_wvalid), 64'd1);
      #1;
      rstn = 1'b0;
      #1;
      chk("t6_rst_wvalid", 64'(m_wvalid), 64'd0);
      chk("t6_rst_fifo_ren", 64'(fifo_ren), 64'd0);
      chk("t6_rst_wdata", m_wdata, 64'd0);
      chk("t6_rst_wstrb", 64'(m_wstrb), 64'd0);
      chk("t6_rst_wlast", 64'(m_wlast), 64'd0);
      chk("t6_rst_credit_full", 64'(credit_full), 64'd0);
      chk("t6_rst_ovf", 64'(credit_ovf), 64'd0);
      do_reset();

      // Random AW timing and 50% ready over 1000 beats.
      nb    = 0;
      total = 0;
      while (total < 1000) begin
         len = $urandom_range(1, 8);
         if (total + len > 1000) len = 1000 - total;
         load_burst(len);
         total += len;
         nb++;
      end
      beats       = 0;
      bursts_done = 0;
      aws         = 0;
      for (int c = 0; c < 20000 && exp_q.size() != 0; c++) begin
         aw = (aws < nb) && !credit_full && ($urandom_range(0, 3) == 0);
         if (aw) aws++;
         cyc(aw, 1'($urandom_range(0, 1)));
      end
      chk("t7_all_drained", exp_q.size(), 0);
      chk("t7_beats", beats, 1000);
      chk("t7_bursts", bursts_done, nb);
      chk("t7_no_ovf", 64'(credit_ovf), 64'd0);

      chk("axi_hold_stable", hold_viol, 0);
      chk("ren_when_empty", ren_empty_err, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
